// File: rtl/latency_memory.sv
// Unified instruction/data memory with a fixed, parameterised read latency.
// Writes take effect on the edge they are seen; reads are held by the requester until ready.
module latency_memory #(
    parameter int unsigned ADDR_WIDTH   = 10,
    parameter int unsigned READ_LATENCY = 2,
    parameter string       INIT_FILE    = ""
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] mem_addr,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] mem_write_data,
    output logic [31:0] mem_read_data,
    output logic        mem_ready,
    output logic        mem_error
);

    typedef enum logic [1:0] {StIdle, StWait, StValid} state_e;

    localparam logic [3:0] LastCnt = 4'(READ_LATENCY - 1);

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] lat_addr_q, lat_addr_d;
    logic [31:0] rdata_q, rdata_d;
    logic        ready_q, ready_d;
    logic        err_q, err_d;
    logic        new_req, load;

    logic [31:0] mem_q [2**ADDR_WIDTH];

    function automatic logic is_bad(input logic [31:0] a);
        return (a[1:0] != 2'b00) || ((a >> (ADDR_WIDTH + 2)) != 32'd0);
    endfunction

    logic [ADDR_WIDTH-1:0] word;
    logic                  addr_bad;
    logic                  wr_ok;
    logic [31:0]           load_val;

    assign word     = mem_addr[ADDR_WIDTH+1:2];
    assign addr_bad = is_bad(mem_addr);
    assign wr_ok    = mem_write & ~addr_bad;
    // A load only happens while mem_addr matches the latched address, so a same-edge
    // write to it is always to the same word and is forwarded.
    assign load_val = addr_bad ? 32'd0 : (wr_ok ? mem_write_data : mem_q[word]);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        lat_addr_d = lat_addr_q;
        rdata_d    = rdata_q;
        new_req    = 1'b0;
        load       = 1'b0;

        case (state_q)
            StIdle: begin
                if (mem_read) new_req = 1'b1;
            end
            StWait: begin
                if (!mem_read) begin
                    state_d = StIdle;
                end else if (mem_addr != lat_addr_q) begin
                    new_req = 1'b1;
                end else if (cnt_q == LastCnt) begin
                    load    = 1'b1;
                    state_d = StValid;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            StValid: begin
                if (!mem_read) begin
                    state_d = StIdle;
                end else if (mem_addr != lat_addr_q) begin
                    new_req = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        if (new_req) begin
            lat_addr_d = mem_addr;
            cnt_d      = 4'd1;
            if (READ_LATENCY == 1) begin
                load    = 1'b1;
                state_d = StValid;
            end else begin
                state_d = StWait;
            end
        end

        if (load) rdata_d = load_val;

        ready_d = (state_d == StValid);
        err_d   = (new_req | mem_write) & addr_bad;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            cnt_q      <= 4'd0;
            lat_addr_q <= 32'd0;
            rdata_q    <= 32'd0;
            ready_q    <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            lat_addr_q <= lat_addr_d;
            rdata_q    <= rdata_d;
            ready_q    <= ready_d;
            err_q      <= err_d;
        end
    end

    // The array is deliberately outside reset so contents survive it.
    always_ff @(posedge clk) begin
        if (wr_ok) mem_q[word] <= mem_write_data;
    end

    assign mem_read_data = rdata_q;
    assign mem_ready     = ready_q;
    assign mem_error     = err_q;

endmodule

// File: tb/tb_latency_memory.sv
// Scoreboard bench: three latency builds (2, 1, 4) share one stimulus stream and are each
// checked cycle by cycle against a request-age reference model.
module tb_latency_memory;

    localparam int AW = 10;
    localparam int NW = 1 << AW;

    logic        clk = 1'b0;
    logic        reset, mem_read, mem_write;
    logic [31:0] mem_addr, mem_write_data;
    logic [31:0] rdata [3];
    logic        ready [3];
    logic        err   [3];

    always #5 clk = ~clk;

    latency_memory #(.ADDR_WIDTH(AW), .READ_LATENCY(2), .INIT_FILE("")) u_l2 (
        .clk(clk), .reset(reset), .mem_addr(mem_addr), .mem_read(mem_read),
        .mem_write(mem_write), .mem_write_data(mem_write_data),
        .mem_read_data(rdata[0]), .mem_ready(ready[0]), .mem_error(err[0]));

    latency_memory #(.ADDR_WIDTH(AW), .READ_LATENCY(1), .INIT_FILE("")) u_l1 (
        .clk(clk), .reset(reset), .mem_addr(mem_addr), .mem_read(mem_read),
        .mem_write(mem_write), .mem_write_data(mem_write_data),
        .mem_read_data(rdata[1]), .mem_ready(ready[1]), .mem_error(err[1]));

    latency_memory #(.ADDR_WIDTH(AW), .READ_LATENCY(4), .INIT_FILE("")) u_l4 (
        .clk(clk), .reset(reset), .mem_addr(mem_addr), .mem_read(mem_read),
        .mem_write(mem_write), .mem_write_data(mem_write_data),
        .mem_read_data(rdata[2]), .mem_ready(ready[2]), .mem_error(err[2]));

    typedef struct packed {
        logic        rdy;
        logic        er;
        logic [31:0] data;
    } resp_t;

    resp_t       exp_q [3][$];
    logic [31:0] m_mem [NW];
    int          m_age [3];
    logic [31:0] m_req [3];
    logic [31:0] m_data[3];
    int          n_checks = 0;
    int          n_fail   = 0;

    function automatic int lat_of(input int i);
        return (i == 0) ? 2 : ((i == 1) ? 1 : 4);
    endfunction

    function automatic logic bad(input logic [31:0] a);
        return (a[1:0] != 2'b00) || (a >= 32'(4 * NW));
    endfunction

    // Reference: a read completes once the same address has been requested on L consecutive
    // edges; it stays ready while held; an address change or drop starts over.
    task automatic model_edge();
        resp_t       r;
        logic        b;
        logic        nreq;
        logic [31:0] w;
        b = bad(mem_addr);
        w = {22'd0, mem_addr[AW+1:2]};
        if (!reset && mem_write && !b) m_mem[w] = mem_write_data;
        for (int i = 0; i < 3; i++) begin
            nreq = 1'b0;
            if (reset) begin
                m_age[i]  = 0;
                m_data[i] = 32'd0;
                r = '0;
            end else begin
                if (!mem_read) begin
                    m_age[i] = 0;
                end else if (m_age[i] == 0 || mem_addr != m_req[i]) begin
                    m_req[i] = mem_addr;
                    m_age[i] = 1;
                    nreq     = 1'b1;
                end else if (m_age[i] < 100) begin
                    m_age[i]++;
                end
                if (mem_read && m_age[i] == lat_of(i)) m_data[i] = b ? 32'd0 : m_mem[w];
                r.rdy  = mem_read && (m_age[i] >= lat_of(i));
                r.er   = (nreq || mem_write) && b;
                r.data = m_data[i];
            end
            exp_q[i].push_back(r);
        end
    endtask

    task automatic step(input logic r, input logic rd, input logic wr,
                        input logic [31:0] a, input logic [31:0] wd);
        reset = r; mem_read = rd; mem_write = wr; mem_addr = a; mem_write_data = wd;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic cmp(input string name, input int i, input logic [31:0] act,
                       input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s lat=%0d t=%0t: got %h, expected %h", name, lat_of(i), $time,
                     act, req);
        end
    endtask

    always @(negedge clk) begin
        resp_t e;
        for (int i = 0; i < 3; i++) begin
            if (exp_q[i].size() > 0) begin
                e = exp_q[i].pop_front();
                cmp("mem_ready", i, {31'd0, ready[i]}, {31'd0, e.rdy});
                cmp("mem_error", i, {31'd0, err[i]}, {31'd0, e.er});
                cmp("mem_read_data", i, rdata[i], e.data);
            end
        end
    end

    task automatic hold_read(input logic [31:0] a, input int n);
        for (int k = 0; k < n; k++) step(1'b0, 1'b1, 1'b0, a, 32'd0);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        step(1'b0, 1'b0, 1'b1, a, d);
    endtask

    initial begin
        logic [31:0] cur, a;
        logic        rd, w, rs;
        for (int i = 0; i < 3; i++) begin
            m_age[i] = 0; m_req[i] = '0; m_data[i] = '0;
        end
        step(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
        step(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
        for (int k = 0; k < NW; k++) wr(32'(4 * k), $urandom);

        // Basic read, then drop: data holds.
        wr(32'h40, 32'h1234_5678);
        hold_read(32'h40, 5);
        idle(2);
        // Address changes mid-wait.
        wr(32'h40, 32'hAAAA_0001);
        wr(32'h44, 32'hBBBB_0002);
        hold_read(32'h40, 1);
        hold_read(32'h44, 5);
        idle(1);
        // Misaligned and out-of-range reads, bad write, no aliasing.
        hold_read(32'h42, 5);
        idle(1);
        hold_read(32'h1000, 5);
        idle(1);
        wr(32'h1000, 32'hDEAD_BEEF);
        hold_read(32'h0, 5);
        idle(1);
        // Write forwarded on the load edge.
        wr(32'h80, 32'h1111_1111);
        hold_read(32'h80, 1);
        step(1'b0, 1'b1, 1'b1, 32'h80, 32'h2222_2222);
        hold_read(32'h80, 3);
        idle(1);
        hold_read(32'h80, 5);
        idle(1);
        // Reset in the middle of a request with the read still high.
        hold_read(32'h40, 1);
        step(1'b1, 1'b1, 1'b0, 32'h40, 32'd0);
        hold_read(32'h40, 5);
        idle(1);

        cur = 32'h40;
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 7) == 0) begin
                case ($urandom_range(0, 15))
                    0:       cur = {$urandom_range(0, 63), 2'b00} | 32'($urandom_range(1, 3));
                    1:       cur = 32'h1000 + 32'(4 * $urandom_range(0, 255));
                    default: cur = {22'd0, 8'($urandom_range(0, 31)), 2'b00};
                endcase
            end
            a  = cur;
            rs = ($urandom_range(0, 199) == 0);
            rd = ($urandom_range(0, 5) != 0);
            w  = !rs && ($urandom_range(0, 4) == 0);
            step(rs, rd, w, a, $urandom);
        end
        idle(2);
        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
